// File: rtl/relax_osc_freq_counter_if.sv
// Control and readout signals between the oscillator frequency counter and its host.
interface relax_osc_freq_counter_if;
  logic       ena;
  logic       osc_in;
  logic       start;
  logic       continuous;
  logic       byte_sel;
  logic [7:0] data_out;
  logic       busy;
  logic       valid;
  logic       overflow;

  modport master (
    output ena, osc_in, start, continuous, byte_sel,
    input  data_out, busy, valid, overflow
  );

  modport slave (
    input  ena, osc_in, start, continuous, byte_sel,
    output data_out, busy, valid, overflow
  );
endinterface

// File: rtl/relax_osc_freq_counter.sv
// Synchronises the relaxation-oscillator output, counts its rising edges over a
// GATE_CYCLES window and presents the latched count byte-wise.
module relax_osc_freq_counter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  relax_osc_freq_counter_if.slave bus
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, COUNT, LATCH, DONE} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [GW-1:0]          gate_q;
  logic [CNT_W-1:0]       edge_q;
  logic [CNT_W-1:0]       edge_d;
  logic [CNT_W-1:0]       result_q;
  logic                   sat_q;
  logic                   sat_d;
  logic                   ovf_q;
  logic                   busy_q;
  logic                   valid_q;
  logic                   rise;
  logic [15:0]            result_wide;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.osc_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Saturating edge count; a rise arriving at full scale marks the result as clipped.
  always_comb begin
    edge_d = edge_q;
    sat_d  = sat_q;
    if (rise) begin
      if (edge_q == CNT_MAX) sat_d = 1'b1;
      else                   edge_d = edge_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gate_q   <= '0;
      edge_q   <= '0;
      sat_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.ena) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start || bus.continuous) begin
              state_q <= COUNT;
              gate_q  <= '0;
              edge_q  <= '0;
              sat_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          COUNT: begin
            gate_q <= gate_q + GW'(1);
            edge_q <= edge_d;
            sat_q  <= sat_d;
            if (gate_q == GATE_LAST) begin
              state_q <= LATCH;
              busy_q  <= 1'b0;
            end
          end
          LATCH: begin
            result_q <= edge_q;
            ovf_q    <= sat_q;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
          DONE: begin
            if (bus.continuous) begin
              state_q <= COUNT;
              gate_q  <= '0;
              edge_q  <= '0;
              sat_q   <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Widening to 16 bits zero-extends the upper byte for any CNT_W below 16.
  assign result_wide  = 16'(result_q);
  assign bus.data_out = bus.byte_sel ? result_wide[15:8] : result_wide[7:0];
  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_relax_osc_freq_counter.sv
// Directed and randomized bench for relax_osc_freq_counter; expected counts come from
// a record of the osc_in level seen at every clock edge.
module tb_relax_osc_freq_counter;
  localparam int GA   = 1000;
  localparam int WA   = 16;
  localparam int SA   = 2;
  localparam int GB   = 2000;
  localparam int WB   = 9;
  localparam int SB   = 3;
  localparam int HMAX = 65536;

  logic clk;
  logic rst_n;
  bit   osc;
  int   vectors = 0;
  int   miscompares = 0;
  int   edgeNum = 0;
  bit   hist [HMAX];
  bit   oscAuto = 1'b0;
  int   oscPeriod = 10;
  int   oscHigh = 5;
  int   oscPh = 0;

  relax_osc_freq_counter_if ifA ();
  relax_osc_freq_counter_if ifB ();

  assign ifA.osc_in = osc;
  assign ifB.osc_in = osc;

  relax_osc_freq_counter #(.GATE_CYCLES(GA), .CNT_W(WA), .SYNC_STAGES(SA)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(ifA.slave)
  );

  relax_osc_freq_counter #(.GATE_CYCLES(GB), .CNT_W(WB), .SYNC_STAGES(SB)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(ifB.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Level of osc_in at every edge; reset empties the synchronisers, so it reads as low.
  always @(posedge clk) begin
    edgeNum = edgeNum + 1;
    if (edgeNum < HMAX) begin
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) if (edgeNum - k >= 0) hist[edgeNum - k] = 1'b0;
      end else begin
        hist[edgeNum] = osc;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (oscAuto) begin
        oscPh = (oscPh + 1) % oscPeriod;
        osc   = (oscPh < oscHigh);
      end
    end
  end

  function automatic int rawRises(int e, int g, int s);
    int n = 0;
    for (int m = e + 1; m <= e + g; m++) if (hist[m - s] && !hist[m - s - 1]) n++;
    return n;
  endfunction

  function automatic logic getBusy(int sel);
    return sel != 0 ? ifB.busy : ifA.busy;
  endfunction

  function automatic logic getValid(int sel);
    return sel != 0 ? ifB.valid : ifA.valid;
  endfunction

  function automatic logic getOvf(int sel);
    return sel != 0 ? ifB.overflow : ifA.overflow;
  endfunction

  function automatic logic [7:0] getData(int sel);
    return sel != 0 ? ifB.data_out : ifA.data_out;
  endfunction

  task automatic applyStimulus(int sel, logic en, logic st, logic cont, logic bs);
    if (sel != 0) begin
      ifB.ena = en; ifB.start = st; ifB.continuous = cont; ifB.byte_sel = bs;
    end else begin
      ifA.ena = en; ifA.start = st; ifA.continuous = cont; ifA.byte_sel = bs;
    end
  endtask

  task automatic setOscPeriodic(int p, int hi);
    oscPeriod = p;
    oscHigh   = hi;
    oscPh     = $urandom_range(0, p - 1);
    oscAuto   = 1'b1;
  endtask

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkNear(string tag, int obs, int nom);
    checkOutput(tag, (obs >= nom - 1 && obs <= nom + 1), 1);
  endtask

  // One single-shot measurement; optional stray start pulse and manual osc rise.
  task automatic runOnce(int sel, int g, int s, int w, string tag, int midStart, int riseAt,
                         output int obsRes, output int expRes);
    int e;
    int busyCnt = 0;
    int vEdge = -1;
    int vCnt = 0;
    int raw;
    int maxv;
    logic [7:0] lo;
    logic [7:0] hi;
    @(negedge clk);
    applyStimulus(sel, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 e = edgeNum;
    for (int k = 0; k < g + 20; k++) begin
      @(negedge clk);
      applyStimulus(sel, 1'b1, (k == midStart), 1'b0, 1'b0);
      if (riseAt >= 0 && edgeNum + 1 == e + riseAt) osc = 1'b1;
      if (getBusy(sel)) busyCnt++;
      if (getValid(sel)) begin
        vCnt++;
        vEdge = edgeNum;
      end
    end
    checkOutput({tag, "_busyLen"}, busyCnt, g);
    checkOutput({tag, "_validEdge"}, vEdge - e, g + 1);
    checkOutput({tag, "_validCnt"}, vCnt, 1);
    raw    = rawRises(e, g, s);
    maxv   = (1 << w) - 1;
    expRes = (raw > maxv) ? maxv : raw;
    checkOutput({tag, "_ovf"}, getOvf(sel), (raw > maxv));
    #1 lo = getData(sel);
    checkOutput({tag, "_lo"}, lo, expRes & 255);
    applyStimulus(sel, 1'b1, 1'b0, 1'b0, 1'b1);
    #1 hi = getData(sel);
    checkOutput({tag, "_hi"}, hi, (expRes >> 8) & 255);
    applyStimulus(sel, 1'b1, 1'b0, 1'b0, 1'b0);
    obsRes = {16'd0, hi, lo};
  endtask

  initial begin
    int obs;
    int exp;
    int lastExp;
    int e;
    int vCnt;
    int vPrev;
    int nV;
    int busyAfter;
    int raw;
    bit dropped;

    rst_n = 1'b0;
    osc   = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0);
    setOscPeriodic(10, 5);

    repeat (4) begin
      @(negedge clk);
      checkOutput("rstBusyA", ifA.busy, 1'b0);
      checkOutput("rstBusyB", ifB.busy, 1'b0);
    end
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rstBusy", ifA.busy, 1'b0);
    checkOutput("rstValid", ifA.valid, 1'b0);
    checkOutput("rstData", ifA.data_out, 8'h00);
    checkOutput("rstOvf", ifA.overflow, 1'b0);
    checkOutput("rstValidB", ifB.valid, 1'b0);

    $display("[TB] single shot, period 10");
    runOnce(0, GA, SA, WA, "p10", -1, -1, obs, exp);
    checkNear("p10_tol", obs, 100);

    $display("[TB] stray start during the window");
    runOnce(0, GA, SA, WA, "midStart", $urandom_range(10, 900), -1, obs, lastExp);
    checkNear("midStart_tol", obs, 100);

    $display("[TB] enable dropped mid-window");
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 e = edgeNum;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("abortBusyBefore", ifA.busy, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abortBusyAfter", ifA.busy, 1'b0);
    vCnt = 0;
    for (int k = 0; k < GA + 100; k++) begin
      @(negedge clk);
      if (k == 3) applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (ifA.valid || ifA.busy) vCnt++;
    end
    checkOutput("abortNoActivity", vCnt, 0);
    checkOutput("abortKeepData", ifA.data_out, lastExp & 255);
    checkOutput("abortKeepOvf", ifA.overflow, 1'b0);

    $display("[TB] saturation on the 9-bit instance");
    setOscPeriodic(2, 1);
    runOnce(1, GB, SB, WB, "sat", -1, -1, obs, exp);
    checkOutput("satVal", obs, 511);
    setOscPeriodic(8, 4);
    runOnce(1, GB, SB, WB, "p8", -1, -1, obs, exp);
    checkNear("p8_tol", obs, 250);
    checkOutput("p8_ovfClear", ifB.overflow, 1'b0);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] continuous mode, period 20");
    setOscPeriodic(20, 10);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 e = edgeNum;
    nV = 0; vPrev = 0; busyAfter = 0; dropped = 1'b0;
    for (int k = 0; k < 3 * (GA + 2) + 40; k++) begin
      @(negedge clk);
      if (ifA.valid) begin
        nV++;
        if (nV == 1) checkOutput("contFirst", edgeNum - e, GA + 1);
        else         checkOutput("contGap", edgeNum - vPrev, GA + 2);
        raw = rawRises(edgeNum - GA - 1, GA, SA);
        checkOutput("contData", ifA.data_out, raw & 255);
        checkNear("contTol", int'(ifA.data_out), 50);
        vPrev = edgeNum;
      end
      if (nV == 2 && !dropped && ifA.busy && edgeNum > vPrev + 100) begin
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
        dropped = 1'b1;
      end
      if (nV == 3 && ifA.busy) busyAfter++;
    end
    checkOutput("contCount", nV, 3);
    checkOutput("contIdle", busyAfter, 0);

    $display("[TB] randomized oscillator shapes");
    for (int i = 0; i < 3; i++) begin
      int p;
      p = $urandom_range(6, 40);
      setOscPeriodic(p, $urandom_range(2, p - 2));
      runOnce(0, GA, SA, WA, "rand", -1, -1, obs, exp);
      checkNear("rand_tol", obs, (GA + p / 2) / p);
    end

    $display("[TB] edge on the last window cycle and just after");
    @(negedge clk);
    oscAuto = 1'b0;
    osc = 1'b0;
    runOnce(0, GA, SA, WA, "lastIn", -1, GA - SA, obs, exp);
    checkOutput("lastInVal", obs, 1);
    @(negedge clk);
    osc = 1'b0;
    runOnce(0, GA, SA, WA, "lastOut", -1, GA - SA + 1, obs, exp);
    checkOutput("lastOutVal", obs, 0);

    $display("[TB] oscillator held high through reset");
    @(negedge clk);
    osc = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst2Data", ifA.data_out, 8'h00);
    runOnce(0, GA, SA, WA, "heldHigh", -1, -1, obs, exp);
    checkOutput("heldHighMax1", (obs <= 1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/relax_osc_freq_counter.md
Name: relax_osc_freq_counter

Overview:
- Digital stage directly downstream of the relaxation oscillator.
- Samples the asynchronous oscillator square-wave output on the system clock and counts its rising edges over a fixed gate window of clk cycles.
- Latches the count as a frequency measurement and presents it byte-wise on the dedicated outputs, giving an on-chip readout of oscillator frequency.

Parameters:
- GATE_CYCLES, 1000: gate window length in clk cycles; must be >= 2.
- CNT_W, 16: edge-counter and result width; must be 9..16.
- SYNC_STAGES, 2: synchronizer flop count on osc_in; must be >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- ena  input  1  design enable; low aborts activity.
- osc_in  input  1  oscillator output; asynchronous to clk.
- start  input  1  single-cycle request for one measurement.
- continuous  input  1  when high, measurements repeat back-to-back.
- byte_sel  input  1  0 selects result[7:0]; 1 selects result[CNT_W-1:8], zero-extended to 8 bits.
- data_out  output  8  selected byte of latched result.
- busy  output  1  high while gate window is open.
- valid  output  1  one-cycle pulse when a new result is latched.
- overflow  output  1  latched result saturated.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State IDLE; sync chain, edge-prev flop, gate_cnt, edge_cnt, result and overflow all 0.
  - Outputs: busy=0, valid=0, data_out=0, overflow=0.
  - Reset mid-measurement discards the partial count.
- Synchronizer: osc_in passes through SYNC_STAGES flops; sync_q is the last stage. A prev flop holds last sync_q.
- Edge detection: rise = sync_q & ~prev, always active.
  - An osc_in rising edge held stable is counted (rise high) SYNC_STAGES+1 clk edges later.
  - Pulses of osc_in high or low shorter than 2 clk periods may be lost. Accepted: the input must be below clk/2.
- State IDLE:
  - busy=0.
  - If ena & (start | continuous): go to COUNT next cycle with gate_cnt=0 and edge_cnt=0.
- State COUNT:
  - busy=1; gate_cnt increments every cycle.
  - If rise: edge_cnt increments, saturating at 2^CNT_W-1; a rise while edge_cnt is already at max sets the internal sat flag.
  - When gate_cnt==GATE_CYCLES-1, that cycle's rise is still included. Next cycle: result<=final count, overflow<=sat, state DONE.
  - Window is exactly GATE_CYCLES cycles of rise sampling.
- State DONE (one cycle):
  - valid=1, busy=0.
  - Next state is COUNT (counters cleared) if ena & continuous, else IDLE.
  - Continuous dead time between windows is therefore 2 cycles: the latch cycle and the DONE cycle.
- start:
  - Ignored while in COUNT or DONE; it is not queued.
  - start and continuous together behave as continuous.
- ena low in any state: next state IDLE; partial count discarded; result/overflow retained; valid not asserted.
- data_out is combinational from result and byte_sel. It changes only when result updates or byte_sel changes, and is stable between valid pulses.
- sat and edge_cnt clear at every window start; overflow reflects only the latest result.
- gate_cnt width is clog2(GATE_CYCLES); no wrap occurs because the window terminates at GATE_CYCLES-1.

Test Plan:
- Reset with osc_in toggling and start=1 -> busy, valid, data_out, overflow all 0 on the cycle after rst_n rises; no COUNT entry while rst_n is low.
- osc_in period 10 clk (50% duty), GATE_CYCLES=1000, one start pulse:
  - busy high for exactly 1000 cycles; valid pulses once.
  - result is 100 ±1 (phase-dependent).
  - byte_sel=0 gives 0x64; byte_sel=1 gives 0x00.
- CNT_W=9, GATE_CYCLES=2000, osc period 2 clk -> result 511, overflow=1. Next run with period 8 clk -> result 250 ±1, overflow=0.
- continuous=1, osc period 20 clk, GATE_CYCLES=400 -> valid pulses every 402 cycles, each result 20 ±1. Drop continuous during a window -> that window completes, then IDLE.
- Pulse start mid-COUNT -> no restart, window length unchanged. Drive ena low mid-window -> busy falls next cycle, no valid, previous result still on data_out.
- osc_in held high from reset, start pulsed -> at most one edge counted (result 0 or 1). Also verify an edge on the final window cycle is counted and an edge on the cycle after is not.
